// File: rtl/display_controller.sv
// Six-digit hexadecimal 7-segment driver: captures a 24-bit value, decodes
// each nibble to segments (bit0=a .. bit6=g) and registers all six digits together.
module display_controller #(
  parameter int ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] data_to_display,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5
);

  localparam logic [6:0] SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  logic [23:0] r_data;
  logic [6:0]  w_seg [6];
  logic [6:0]  r_hex [6];

  // Codes are written lit-low; the active-high variant is the bitwise inverse.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0:    code = 7'h40;
      4'h1:    code = 7'h79;
      4'h2:    code = 7'h24;
      4'h3:    code = 7'h30;
      4'h4:    code = 7'h19;
      4'h5:    code = 7'h12;
      4'h6:    code = 7'h02;
      4'h7:    code = 7'h78;
      4'h8:    code = 7'h00;
      4'h9:    code = 7'h10;
      4'hA:    code = 7'h08;
      4'hB:    code = 7'h03;
      4'hC:    code = 7'h46;
      4'hD:    code = 7'h21;
      4'hE:    code = 7'h06;
      default: code = 7'h0E;
    endcase
    return (ACTIVE_LOW != 0) ? code : ~code;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_data <= '0;
    else     r_data <= data_to_display;
  end

  always_comb begin
    for (int unsigned k = 0; k < 6; k++) begin
      w_seg[k] = seg_decode(r_data[4*k +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < 6; k++) begin
      if (rst) r_hex[k] <= SEG_OFF;
      else     r_hex[k] <= w_seg[k];
    end
  end

  assign hex0 = r_hex[0];
  assign hex1 = r_hex[1];
  assign hex2 = r_hex[2];
  assign hex3 = r_hex[3];
  assign hex4 = r_hex[4];
  assign hex5 = r_hex[5];

endmodule

// File: tb/tb_display_controller.sv
// Scoreboard bench for display_controller: both polarities driven in parallel,
// expected digits derived from the input history and the hex-digit segment table.
module tb_display_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] data;

  logic [6:0] l0, l1, l2, l3, l4, l5;
  logic [6:0] h0, h1, h2, h3, h4, h5;

  int checks = 0;
  int errors = 0;

  logic [41:0] exp_q [$];
  logic        hist_rst [$];
  logic [23:0] hist_data [$];

  localparam logic [6:0] SEG_TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  display_controller #(.ACTIVE_LOW(1)) u_dut_lo (
    .clk(clk), .rst(rst), .data_to_display(data),
    .hex0(l0), .hex1(l1), .hex2(l2), .hex3(l3), .hex4(l4), .hex5(l5)
  );

  display_controller #(.ACTIVE_LOW(0)) u_dut_hi (
    .clk(clk), .rst(rst), .data_to_display(data),
    .hex0(h0), .hex1(h1), .hex2(h2), .hex3(h3), .hex4(h4), .hex5(h5)
  );

  always #5 clk = ~clk;

  // Lit-low image of a value: hex5 in the top 7 bits, hex0 in the bottom.
  function automatic logic [41:0] digits_of(input logic [23:0] v);
    logic [41:0] r;
    logic [3:0]  nib;
    r = '0;
    for (int k = 0; k < 6; k++) begin
      nib = v[4*k +: 4];
      r[7*k +: 7] = SEG_TBL[nib];
    end
    return r;
  endfunction

  // Outputs after an edge are off if rst was high at that edge; otherwise they
  // show what was captured one edge earlier (zero if that edge was a reset).
  task automatic apply(input logic r, input logic [23:0] d);
    int n;
    logic [41:0] e;
    rst  = r;
    data = d;
    @(posedge clk);
    #1;
    hist_rst.push_back(r);
    hist_data.push_back(d);
    n = hist_rst.size() - 1;
    if (r)                          e = {6{7'h7F}};
    else if (n == 0 || hist_rst[n-1]) e = digits_of(24'h000000);
    else                            e = digits_of(hist_data[n-1]);
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    logic [41:0] e, act_lo, act_hi;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e      = exp_q.pop_front();
        act_lo = {l5, l4, l3, l2, l1, l0};
        act_hi = {h5, h4, h3, h2, h1, h0};
        checks++;
        if (act_lo !== e) begin
          errors++;
          $display("FAIL lo_digits @%0t: got %h expected %h", $time, act_lo, e);
        end
        checks++;
        if (act_hi !== ~e) begin
          errors++;
          $display("FAIL hi_digits @%0t: got %h expected %h", $time, act_hi, ~e);
        end
      end
    end
  end

  initial begin : driver
    rst  = 1'b1;
    data = 24'h5A5A5A;
    apply(1'b1, 24'h5A5A5A);
    apply(1'b1, 24'h123456);
    apply(1'b0, 24'h000000);
    apply(1'b0, 24'h000000);
    apply(1'b0, 24'h123456);
    apply(1'b0, 24'h123456);
    apply(1'b0, 24'hABCDEF);
    apply(1'b0, 24'hABCDEF);
    apply(1'b0, 24'hFFFFFF);
    apply(1'b0, 24'hDEADBE);
    apply(1'b0, 24'hDEADBE);
    apply(1'b1, 24'hDEADBE);
    apply(1'b0, 24'hDEADBE);
    apply(1'b0, 24'hDEADBE);
    apply(1'b0, 24'hDEADBE);
    apply(1'b0, 24'h888888);
    apply(1'b0, 24'h888888);
    for (int i = 0; i < 300; i++) begin
      apply($urandom_range(0, 15) == 0, 24'($urandom));
    end
    apply(1'b0, 24'h0F1E2D);
    apply(1'b0, 24'h3C4B5A);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    checks++;
    if (checks < 2 * 319) begin
      errors++;
      $display("FAIL compare_count: got %0d expected at least %0d", checks, 2 * 319);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL timeout: got time %0t expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/display_controller.md
Name:
display_controller

Overview:
- Drives six 7-segment digits (DE10-Lite style HEX0..HEX5) from a 24-bit value, one hex nibble per digit.
- Used in the I/O subsystem to show processor data, e.g. a memory-mapped register, in hexadecimal.
- Contains one input capture register, six nibble-to-segment decoders and a registered output stage.

Parameters:
- ACTIVE_LOW, 1: 1 means a segment is lit by driving 0 (common-anode board); 0 means every output bit is inverted (lit = 1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- data_to_display  input  24  value to show; bits [3:0] go to hex0 and bits [23:20] go to hex5.
- hex0  output  7  segments of digit 0 (least significant nibble, data[3:0]).
- hex1  output  7  segments of digit 1 (data[7:4]).
- hex2  output  7  segments of digit 2 (data[11:8]).
- hex3  output  7  segments of digit 3 (data[15:12]).
- hex4  output  7  segments of digit 4 (data[19:16]).
- hex5  output  7  segments of digit 5 (most significant nibble, data[23:20]).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Segment bit order for every hexN: bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.
- Reset: when rst=1 at a rising edge, all six hexN outputs become "all segments off".
  - With ACTIVE_LOW=1 this value is 7'h7F.
  - The internal capture register clears to 24'h000000.
- Pipeline, two register stages:
  - Edge N: data_to_display is captured into an internal register.
  - Edge N+1: the decoded segments are registered onto hexN.
  - Latency from input to outputs is 2 clk edges. No handshake or enable; data is sampled every cycle.
- Digit mapping: digit k decodes nibble data[4k+3:4k] for k=0..5. All six digits update in the same cycle, so digits are never torn across cycles.
- Decode table for ACTIVE_LOW=1, values given as hex of bits [6:0]:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - With ACTIVE_LOW=0, each value is the bitwise inverse of the table entry.
- No leading-zero blanking: all six digits are always lit, including zeros.
- Reset asserted mid-stream: both pipeline stages clear on the same edge.
  - Outputs read "off" on the cycle after that edge.
  - After rst deasserts, the outputs show 0x000000 (all digits = 40) for one cycle. Fresh input data appears 2 edges after deassertion.
- Input changes every cycle: the outputs follow with a 2-cycle delay, with no dropped values.

Test Plan:
- Reset: hold rst=1 for 2 cycles -> hex0..hex5 = 7F each, regardless of data_to_display.
- data=24'h000000, wait 2 edges -> every hexN = 40.
- data=24'h123456 -> hex5..hex0 = 79, 24, 30, 19, 12, 02.
- data=24'hABCDEF -> hex5..hex0 = 08, 03, 46, 21, 06, 0E.
- data=24'hFFFFFF then 24'hDEADBE on consecutive cycles -> outputs show all 0E, then next cycle hex5..hex0 = 21, 06, 08, 21, 03, 06. This checks the 2-cycle latency and back-to-back updates.
- Assert rst for one cycle while displaying 24'hDEADBE -> all hexN = 7F the cycle after, then 40s, then live data again. Also run with ACTIVE_LOW=0 and check the inverted codes, e.g. digit 8 = 7F.
